// File: rtl/sp_ram_mux_pkg.sv
// Shared types and constants for the two-master single-port RAM front end.
package sp_ram_mux_pkg;

  localparam int NUM_PORTS   = 2;
  localparam int WORD_OFFSET = 2;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_idx_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } ram_req_t;

endpackage

// File: rtl/sp_ram_mux_if.sv
// One master-side req/gnt/rvalid access port (byte address, 32-bit data).
interface sp_ram_mux_if;

  logic        req;
  logic        gnt;
  logic        rvalid;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/sp_ram_mux_arb.sv
// Two-port arbiter: requests plus last winner in, one-hot grant out (combinational).
// Latency: 0 cycles. Backpressure: losers get no grant and must hold their request.
// SP_RAM_MUX_RR_EN selects round-robin on conflict; otherwise port0 always wins.
module sp_ram_mux_arb
  import sp_ram_mux_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  port_idx_t            last,
  output logic [NUM_PORTS-1:0] gnt
);

`ifdef SP_RAM_MUX_RR_EN
  always_comb begin
    gnt = req;
    // Conflict goes to the port that did not win last time.
    if (&req) gnt = (last == PORT1) ? 2'b01 : 2'b10;
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    gnt = req;
    if (&req) gnt = 2'b01;
  end
`endif

endmodule

// File: rtl/sp_ram_mux.sv
// Arbitrates two masters onto one single-port RAM; byte-to-word address conversion.
// Latency: gnt same cycle as req, rvalid/rdata exactly one cycle after gnt.
// Backpressure: grant only; no response stall. SP_RAM_MUX_RR_EN enables round-robin.
module sp_ram_mux
  import sp_ram_mux_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  sp_ram_mux_if.slave           port0,
  sp_ram_mux_if.slave           port1,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  logic [NUM_PORTS-1:0] gnt;
  port_idx_t            last_q;
  port_idx_t            resp_owner_q;
  logic                 resp_valid_q;
  ram_req_t             req0;
  ram_req_t             req1;
  ram_req_t             sel;

  sp_ram_mux_arb u_arb (
    .req  ({port1.req, port0.req}),
    .last (last_q),
    .gnt  (gnt)
  );

  assign port0.gnt = gnt[0];
  assign port1.gnt = gnt[1];

  assign req0 = '{addr: port0.addr, we: port0.we, be: port0.be, wdata: port0.wdata};
  assign req1 = '{addr: port1.addr, we: port1.we, be: port1.be, wdata: port1.wdata};

  // Idle cycles drive an all-zero request so the RAM port is quiet.
  always_comb begin
    sel = '0;
    if (gnt[0])      sel = req0;
    else if (gnt[1]) sel = req1;
  end

  assign ram_en_o    = |gnt;
  assign ram_addr_o  = sel.addr[ADDR_WIDTH+WORD_OFFSET-1:WORD_OFFSET];
  assign ram_we_o    = sel.we;
  assign ram_be_o    = sel.be;
  assign ram_wdata_o = sel.wdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{sel.addr[WORD_OFFSET-1:0], sel.addr[31:ADDR_WIDTH+WORD_OFFSET]};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      resp_valid_q <= 1'b0;
      resp_owner_q <= PORT0;
      last_q       <= PORT1;
    end else begin
      resp_valid_q <= ram_en_o;
      if (ram_en_o) begin
        resp_owner_q <= gnt[1] ? PORT1 : PORT0;
        last_q       <= gnt[1] ? PORT1 : PORT0;
      end
    end
  end

  assign port0.rvalid = resp_valid_q & (resp_owner_q == PORT0);
  assign port1.rvalid = resp_valid_q & (resp_owner_q == PORT1);
  assign port0.rdata  = (resp_owner_q == PORT0) ? ram_rdata_i : '0;
  assign port1.rdata  = (resp_owner_q == PORT1) ? ram_rdata_i : '0;

endmodule

// File: tb/tb_sp_ram_mux.sv
// Directed bench for sp_ram_mux with a transaction-level reference model and RAM.
module tb_sp_ram_mux;

  localparam int AW    = 13;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rstn;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  int total = 0;
  int bad   = 0;

  sp_ram_mux_if p0 ();
  sp_ram_mux_if p1 ();

  sp_ram_mux #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .port0       (p0),
    .port1       (p1),
    .ram_en_o    (ram_en),
    .ram_addr_o  (ram_addr),
    .ram_we_o    (ram_we),
    .ram_be_o    (ram_be),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEAD_BEEF : (32'hA500_0000 | i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream RAM: one-cycle read latency, byte-enabled writes.
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= ram[ram_addr];
      end
    end
  end

  // Reference model: golden memory plus the single outstanding response.
  logic [31:0] gmem [DEPTH];
  bit          pend_vld;
  bit          pend_own;
  bit          pend_we;
  logic [31:0] pend_dat;
  bit          last_m;

  always @(negedge clk) begin
    bit          r0, r1, win, any;
    logic [31:0] a, wd;
    logic        we;
    logic [3:0]  be;
    int          word;
    if (!rstn) begin
      chk("rvalid0_in_reset", {31'b0, p0.rvalid}, 32'd0);
      chk("rvalid1_in_reset", {31'b0, p1.rvalid}, 32'd0);
      pend_vld = 0;
      last_m   = 1;
    end else begin
      chk("rvalid0", {31'b0, p0.rvalid}, {31'b0, pend_vld && !pend_own});
      chk("rvalid1", {31'b0, p1.rvalid}, {31'b0, pend_vld && pend_own});
      if (pend_vld && !pend_we)
        chk(pend_own ? "rdata1" : "rdata0", pend_own ? p1.rdata : p0.rdata, pend_dat);
      if (pend_vld)
        chk("rdata_nonowner", pend_own ? p0.rdata : p1.rdata, 32'd0);

      r0  = p0.req;
      r1  = p1.req;
      any = r0 | r1;
`ifdef SP_RAM_MUX_RR_EN
      win = (r0 && r1) ? !last_m : r1;
`else
      win = (r0 && r1) ? 1'b0 : r1;
`endif
      chk("gnt0", {31'b0, p0.gnt}, {31'b0, any && !win});
      chk("gnt1", {31'b0, p1.gnt}, {31'b0, any && win});

      if (any) begin
        a    = win ? p1.addr  : p0.addr;
        we   = win ? p1.we    : p0.we;
        be   = win ? p1.be    : p0.be;
        wd   = win ? p1.wdata : p0.wdata;
        word = int'((a / 4) % DEPTH);
        chk("ram_en", {31'b0, ram_en}, 32'd1);
        chk("ram_addr", 32'(ram_addr), 32'(word));
        chk("ram_we", {31'b0, ram_we}, {31'b0, we});
        chk("ram_be", {28'b0, ram_be}, {28'b0, be});
        chk("ram_wdata", ram_wdata, wd);
        last_m   = win;
        pend_vld = 1;
        pend_own = win;
        pend_we  = we;
        pend_dat = gmem[word];
        if (we)
          for (int b = 0; b < 4; b++)
            if (be[b]) gmem[word][8*b +: 8] = wd[8*b +: 8];
      end else begin
        chk("ram_en_idle", {31'b0, ram_en}, 32'd0);
        chk("ram_idle_fields", {ram_we, ram_be, 19'(ram_addr)}, 32'd0);
        chk("ram_wdata_idle", ram_wdata, 32'd0);
        pend_vld = 0;
      end
    end
  end

  task automatic drive(input int p, input logic [31:0] a, input logic we,
                       input logic [3:0] be, input logic [31:0] wd);
    if (p == 0) begin
      p0.req = 1; p0.addr = a; p0.we = we; p0.be = be; p0.wdata = wd;
    end else begin
      p1.req = 1; p1.addr = a; p1.we = we; p1.be = be; p1.wdata = wd;
    end
  endtask

  task automatic idle(input int p);
    if (p == 0) begin
      p0.req = 0; p0.addr = '0; p0.we = 0; p0.be = '0; p0.wdata = '0;
    end else begin
      p1.req = 0; p1.addr = '0; p1.we = 0; p1.be = '0; p1.wdata = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] exp_g0;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]  = init_word(i);
      gmem[i] = init_word(i);
    end
    ram_rdata = '0;
    rstn = 0;
    idle(0);
    idle(1);

    repeat (2) @(negedge clk);
    chk("lit_rst_rvalid0", {31'b0, p0.rvalid}, 32'd0);
    chk("lit_rst_rvalid1", {31'b0, p1.rvalid}, 32'd0);
    step();
    rstn = 1;

    // Port0 reads byte 0x10 -> word 4.
    drive(0, 32'h10, 0, 4'hF, 32'h0);
    @(negedge clk);
    chk("lit_rd_gnt0", {31'b0, p0.gnt}, 32'd1);
    chk("lit_rd_addr", 32'(ram_addr), 32'd4);
    step();
    idle(0);
    @(negedge clk);
    chk("lit_rd_rvalid0", {31'b0, p0.rvalid}, 32'd1);
    chk("lit_rd_rdata0", p0.rdata, 32'hDEAD_BEEF);
    chk("lit_rd_rvalid1", {31'b0, p1.rvalid}, 32'd0);

    // Port1 writes low half of word 8, then reads it back.
    step();
    drive(1, 32'h20, 1, 4'b0011, 32'h1234_5678);
    @(negedge clk);
    chk("lit_wr_we", {31'b0, ram_we}, 32'd1);
    chk("lit_wr_be", {28'b0, ram_be}, 32'h3);
    chk("lit_wr_addr", 32'(ram_addr), 32'd8);
    step();
    idle(1);
    @(negedge clk);
    chk("lit_wr_rvalid1", {31'b0, p1.rvalid}, 32'd1);
    step();
    drive(1, 32'h20, 0, 4'hF, 32'h0);
    step();
    idle(1);
    @(negedge clk);
    chk("lit_wr_readback", p1.rdata, 32'hA500_5678);

    // Six cycles of continuous contention; last winner is port1 here.
    step();
`ifdef SP_RAM_MUX_RR_EN
    exp_g0 = 6'b010101;
`else
    exp_g0 = 6'b111111;
`endif
    drive(0, 32'h40, 0, 4'hF, 32'h0);
    drive(1, 32'h80, 0, 4'hF, 32'h0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("lit_cont_gnt0", {31'b0, p0.gnt}, {31'b0, exp_g0[c]});
      chk("lit_cont_gnt1", {31'b0, p1.gnt}, {31'b0, !exp_g0[c]});
      step();
    end
    idle(0);
    idle(1);
    step();

    // Alternating owners back-to-back.
    drive(0, 32'h10, 0, 4'hF, 32'h0);
    step();
    idle(0);
    drive(1, 32'h20, 0, 4'hF, 32'h0);
    @(negedge clk);
    chk("lit_alt_rvalid0", {31'b0, p0.rvalid}, 32'd1);
    chk("lit_alt_rdata0", p0.rdata, 32'hDEAD_BEEF);
    chk("lit_alt_gnt1", {31'b0, p1.gnt}, 32'd1);
    step();
    idle(1);
    @(negedge clk);
    chk("lit_alt_rvalid1", {31'b0, p1.rvalid}, 32'd1);
    chk("lit_alt_rdata1", p1.rdata, 32'hA500_5678);
    chk("lit_alt_no_rvalid0", {31'b0, p0.rvalid}, 32'd0);
    step();

    // Reset right after a port0 read grant drops the response.
    drive(0, 32'h10, 0, 4'hF, 32'h0);
    step();
    rstn = 0;
    idle(0);
    @(negedge clk);
    chk("lit_mid_rst_rvalid0", {31'b0, p0.rvalid}, 32'd0);
    step();
    rstn = 1;
    @(negedge clk);
    chk("lit_post_rst_rvalid0", {31'b0, p0.rvalid}, 32'd0);
    step();
    drive(0, 32'h100, 0, 4'hF, 32'h0);
    drive(1, 32'h200, 0, 4'hF, 32'h0);
    @(negedge clk);
    chk("lit_post_rst_gnt0", {31'b0, p0.gnt}, 32'd1);
    chk("lit_post_rst_gnt1", {31'b0, p1.gnt}, 32'd0);
    step();
    idle(0);
    idle(1);
    step();

    // Aliasing: low two bits and bits above the word address are ignored.
    drive(0, 32'h13, 0, 4'hF, 32'h0);
    @(negedge clk);
    chk("lit_alias_lo_addr", 32'(ram_addr), 32'd4);
    step();
    drive(0, 32'hFFFF_0010, 0, 4'hF, 32'h0);
    @(negedge clk);
    chk("lit_alias_hi_addr", 32'(ram_addr), 32'd4);
    chk("lit_alias_lo_rdata", p0.rdata, 32'hDEAD_BEEF);
    step();
    idle(0);
    @(negedge clk);
    chk("lit_alias_hi_rdata", p0.rdata, 32'hDEAD_BEEF);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
